// File: rtl/y86_instr_encoder_pkg.sv
// Shared Y86-64 encoding constants, encoder FSM states, instruction payload type
// and the byte-select helper used by the encoder.
package y86_instr_encoder_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned VALC_W  = 64;

    // Instruction codes
    localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
    localparam logic [ICODE_W-1:0] INOP    = 4'h1;
    localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] ICMOVQ  = 4'h2;
    localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
    localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
    localparam logic [ICODE_W-1:0] IRET    = 4'h9;
    localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

    localparam logic [3:0] FNONE = 4'h0;
    localparam logic [3:0] RNONE = 4'hF;

    // Error causes reported on err_code_o
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ICODE = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Canonicalised instruction as latched by the encoder
    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [VALC_W-1:0] valc;
        logic              need_regids;
        logic              need_valc;
    } instr_t;

    // Byte k of the little-endian encoding of f
    function automatic logic [7:0] instr_byte(input instr_t f, input logic [3:0] k);
        logic [2:0]        v;
        logic [VALC_W-1:0] sh;
        v  = 3'(k - 4'd1 - {3'b000, f.need_regids});
        sh = f.valc >> {v, 3'b000};
        if (k == 4'd0)
            instr_byte = {f.icode, f.ifun};
        else if (f.need_regids && (k == 4'd1))
            instr_byte = {f.ra, f.rb};
        else if (f.need_valc)
            instr_byte = sh[7:0];
        else
            instr_byte = 8'h00;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational Y86-64 length decode from icode.
// Ports: icode (in), need_regids/need_valC (out), len (out, bytes), valid (out, icode known).
module y86_instr_len
    import y86_instr_encoder_pkg::*;
(
    input  logic [3:0] icode,
    output logic       need_regids,
    output logic       need_valC,
    output logic [3:0] len,
    output logic       valid
);

    always_comb begin
        need_regids = 1'b0;
        need_valC   = 1'b0;
        valid       = 1'b1;
        case (icode)
            IHALT, INOP, IRET:         ;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                need_regids = 1'b1;
                need_valC   = 1'b1;
            end
            IJXX, ICALL:               need_valC = 1'b1;
            default:                   valid = 1'b0;
        endcase
        len = 4'd1 + {3'b000, need_regids} + (need_valC ? 4'd8 : 4'd0);
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder: accepts decoded fields over valid/ready and writes
// the canonical byte encoding into instruction memory, one byte per clock.
// Ports: clk_i/rst_i (sync active-high); addr_load_i/addr_i set the write pointer
// in IDLE; in_valid_i/in_ready_o handshake with icode_i/ifun_i/rA_i/rB_i/valC_i;
// mem_we_o/mem_addr_o/mem_wdata_o byte write port; next_addr_o write pointer;
// instr_done_o last-byte pulse; err_o/err_code_o sticky error.
module y86_instr_encoder
    import y86_instr_encoder_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = 1024,
    parameter int unsigned ADDR_W    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              addr_load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [3:0]        rA_i,
    input  logic [3:0]        rB_i,
    input  logic [63:0]       valC_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              instr_done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    instr_t            cur_q, cur_n;
    logic [3:0]        len_q, len_n;
    logic [3:0]        idx_q, idx_n;

    logic              we_n, done_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic [1:0]        code_n;

    logic              in_need_regids, in_need_valc, in_icode_ok;
    logic [3:0]        in_len;
    instr_t            in_f;
    logic              last, accept, range_bad;
    logic              start, emit;
    logic [3:0]        emit_k, emit_len;
    instr_t            emit_f;

    y86_instr_len u_len (
        .icode       (icode_i),
        .need_regids (in_need_regids),
        .need_valC   (in_need_valc),
        .len         (in_len),
        .valid       (in_icode_ok)
    );

    // Canonicalised incoming instruction
    always_comb begin
        in_f.icode       = icode_i;
        in_f.ifun        = ifun_i;
        in_f.ra          = (icode_i == IIRMOVQ) ? RNONE : rA_i;
        in_f.rb          = ((icode_i == IPUSHQ) || (icode_i == IPOPQ)) ? RNONE : rB_i;
        in_f.valc        = valC_i;
        in_f.need_regids = in_need_regids;
        in_f.need_valc   = in_need_valc;
    end

    // idx_q is the index of the byte currently on the write port
    assign last       = (state_q == ST_EMIT) && (idx_q == (len_q - 4'd1));
    assign in_ready_o = !addr_load_i && ((state_q == ST_IDLE) || last);
    assign accept     = in_valid_i && in_ready_o;
    // Widened by one bit so a pointer near 2^ADDR_W cannot wrap past the check
    assign range_bad  = ({1'b0, ptr_q} + (ADDR_W+1)'(in_len)) > (ADDR_W+1)'(IMEM_SIZE);

    assign next_addr_o = ptr_q;

    // Next-state and registered-output logic
    always_comb begin
        state_n  = state_q;
        ptr_n    = ptr_q;
        cur_n    = cur_q;
        len_n    = len_q;
        idx_n    = idx_q;
        we_n     = 1'b0;
        addr_n   = mem_addr_o;
        wdata_n  = mem_wdata_o;
        done_n   = 1'b0;
        err_n    = err_o;
        code_n   = err_code_o;
        start    = 1'b0;
        emit     = 1'b0;
        emit_k   = 4'd0;
        emit_len = len_q;
        emit_f   = cur_q;

        case (state_q)
            ST_IDLE: begin
                if (addr_load_i)
                    ptr_n = addr_i;
                else if (accept)
                    start = 1'b1;
            end
            ST_EMIT: begin
                if (!last) begin
                    emit   = 1'b1;
                    emit_k = idx_q + 4'd1;
                end else if (accept) begin
                    start = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (start) begin
            if (!in_icode_ok) begin
                state_n = ST_ERR;
                err_n   = 1'b1;
                code_n  = ERR_ICODE;
            end else if (range_bad) begin
                state_n = ST_ERR;
                err_n   = 1'b1;
                code_n  = ERR_RANGE;
            end else begin
                state_n  = ST_EMIT;
                cur_n    = in_f;
                len_n    = in_len;
                emit     = 1'b1;
                emit_k   = 4'd0;
                emit_len = in_len;
                emit_f   = in_f;
            end
        end

        // The pointer advances on the edge that presents the last byte
        if (emit) begin
            idx_n   = emit_k;
            we_n    = 1'b1;
            addr_n  = ptr_q + ADDR_W'(emit_k);
            wdata_n = instr_byte(emit_f, emit_k);
            if (emit_k == (emit_len - 4'd1)) begin
                done_n = 1'b1;
                ptr_n  = ptr_q + ADDR_W'(emit_len);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cur_q        <= '0;
            len_q        <= 4'd1;
            idx_q        <= 4'd0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= 8'h00;
            instr_done_o <= 1'b0;
            err_o        <= 1'b0;
            err_code_o   <= ERR_NONE;
        end else begin
            state_q      <= state_n;
            ptr_q        <= ptr_n;
            cur_q        <= cur_n;
            len_q        <= len_n;
            idx_q        <= idx_n;
            mem_we_o     <= we_n;
            mem_addr_o   <= addr_n;
            mem_wdata_o  <= wdata_n;
            instr_done_o <= done_n;
            err_o        <= err_n;
            err_code_o   <= code_n;
        end
    end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Scoreboard bench for y86_instr_encoder: a behavioural model predicts every
// memory write (address, data, done flag, cycle); a monitor checks them.
module tb_y86_instr_encoder;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned IMEM   = 1024;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              addr_load_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [3:0]        icode_i = 4'h0, ifun_i = 4'h0, rA_i = 4'h0, rB_i = 4'h0;
    logic [63:0]       valC_i = '0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic [ADDR_W-1:0] next_addr_o;
    logic              instr_done_o;
    logic              err_o;
    logic [1:0]        err_code_o;

    always #5 clk_i = ~clk_i;

    y86_instr_encoder #(.IMEM_SIZE(IMEM), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_load_i(addr_load_i), .addr_i(addr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .icode_i(icode_i), .ifun_i(ifun_i), .rA_i(rA_i), .rB_i(rB_i), .valC_i(valC_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .next_addr_o(next_addr_o), .instr_done_o(instr_done_o),
        .err_o(err_o), .err_code_o(err_code_o)
    );

    typedef struct {
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc;
    } tb_instr_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;
    logic [63:0] m_ptr = '0;
    logic        m_err = 1'b0;
    logic [1:0]  m_code = 2'b00;
    int          last_cyc = -1;
    int          acc_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoding straight from the length and byte-order rules
    task automatic model_accept(input tb_instr_t f);
        bit          rg, vcn;
        int          n;
        logic [7:0]  b[10];
        logic [3:0]  ra, rb;
        exp_t        e;
        acc_cyc = cyc;
        if (f.ic > 4'hB) begin
            m_err  = 1'b1;
            m_code = 2'b01;
            return;
        end
        rg  = f.ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        vcn = f.ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        n   = 1 + int'(rg) + 8 * int'(vcn);
        if (m_ptr + 64'(n) > 64'(IMEM)) begin
            m_err  = 1'b1;
            m_code = 2'b10;
            return;
        end
        ra = (f.ic == 4'h3) ? 4'hF : f.ra;
        rb = (f.ic == 4'hA || f.ic == 4'hB) ? 4'hF : f.rb;
        b[0] = {f.ic, f.fn};
        if (rg) b[1] = {ra, rb};
        if (vcn)
            for (int i = 0; i < 8; i++) b[int'(rg) + 1 + i] = 8'(f.vc >> (8 * i));
        for (int k = 0; k < n; k++) begin
            e.addr = m_ptr + 64'(k);
            e.data = b[k];
            e.done = (k == n - 1);
            e.cyc  = cyc + 1 + k;
            q.push_back(e);
        end
        last_cyc = cyc + n;
        m_ptr    = m_ptr + 64'(n);
    endtask

    // One cycle of stimulus, with handshake/status checks against the model
    task automatic drive(input logic v, input logic ld, input logic [63:0] a,
                         input tb_instr_t f, output logic acc);
        logic exp_rdy;
        @(negedge clk_i);
        in_valid_i  = v;
        addr_load_i = ld;
        addr_i      = a;
        icode_i     = f.ic;
        ifun_i      = f.fn;
        rA_i        = f.ra;
        rB_i        = f.rb;
        valC_i      = f.vc;
        #1;
        chk("err_o", 64'(err_o), 64'(m_err));
        chk("err_code_o", 64'(err_code_o), 64'(m_code));
        if (cyc >= last_cyc) chk("next_addr_o", next_addr_o, m_ptr);
        exp_rdy = !m_err && !ld && (cyc >= last_cyc);
        chk("in_ready_o", 64'(in_ready_o), 64'(exp_rdy));
        acc = v && exp_rdy;
        if (ld && !m_err && (cyc > last_cyc)) m_ptr = a;
        if (acc) model_accept(f);
    endtask

    task automatic idle(input int n);
        tb_instr_t z;
        logic      acc;
        z = '{ic: 4'h1, fn: 4'h0, ra: 4'h0, rb: 4'h0, vc: 64'h0};
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'h0, z, acc);
    endtask

    task automatic send(input tb_instr_t f);
        logic acc;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b0, 64'h0, f, acc);
            if (acc) return;
        end
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #1;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        addr_load_i = 1'b0;
        q.delete();
        @(negedge clk_i);
        #1;
        rst_i    = 1'b0;
        m_ptr    = '0;
        m_err    = 1'b0;
        m_code   = 2'b00;
        last_cyc = -1;
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            ntests++;
            nfail++;
            $display("FAIL missing_write: addr %0h data %0h never seen by cycle %0d",
                     q[0].addr, q[0].data, cyc);
            void'(q.pop_front());
        end
        if (mem_we_o) begin
            ntests++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_write: addr %0h data %0h cycle %0d",
                         mem_addr_o, mem_wdata_o, cyc);
            end else begin
                e = q.pop_front();
                if (mem_addr_o !== e.addr || mem_wdata_o !== e.data ||
                    instr_done_o !== e.done || cyc != e.cyc) begin
                    nfail++;
                    $display("FAIL write: got addr %0h data %0h done %0b cycle %0d, expected addr %0h data %0h done %0b cycle %0d",
                             mem_addr_o, mem_wdata_o, instr_done_o, cyc,
                             e.addr, e.data, e.done, e.cyc);
                end
            end
        end else if (instr_done_o) begin
            ntests++;
            nfail++;
            $display("FAIL done_without_write: cycle %0d", cyc);
        end
    end

    initial begin
        tb_instr_t f;
        logic      acc;
        logic      v, ld;
        logic [63:0] a;

        // Reset values
        do_reset();
        chk("rst_mem_we", 64'(mem_we_o), 64'd0);
        chk("rst_mem_addr", mem_addr_o, 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
        chk("rst_done", 64'(instr_done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_err_code", 64'(err_code_o), 64'd0);
        chk("rst_next_addr", next_addr_o, 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);

        // IRMOVQ with rA forced to F
        send('{ic: 4'h3, fn: 4'h0, ra: 4'h8, rb: 4'h8, vc: 64'h8});
        idle(12);
        chk("irmovq_next_addr", next_addr_o, 64'd10);

        // Back-to-back OPQ, RET, MRMOVQ with valid held
        do_reset();
        send('{ic: 4'h6, fn: 4'h0, ra: 4'h2, rb: 4'h3, vc: 64'h0});
        send('{ic: 4'h9, fn: 4'h0, ra: 4'h0, rb: 4'h0, vc: 64'h0});
        send('{ic: 4'h5, fn: 4'h0, ra: 4'h4, rb: 4'h7, vc: 64'h0102030405060708});
        idle(12);
        chk("b2b_next_addr", next_addr_o, 64'd13);

        // Invalid icode is terminal
        send('{ic: 4'hC, fn: 4'h0, ra: 4'h0, rb: 4'h0, vc: 64'h0});
        idle(2);
        chk("icode_err", 64'(err_o), 64'd1);
        chk("icode_err_code", 64'(err_code_o), 64'd1);
        f = '{ic: 4'h1, fn: 4'h0, ra: 4'h0, rb: 4'h0, vc: 64'h0};
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 64'h0, f, acc);
        idle(1);

        // Range check at the top of memory
        do_reset();
        f = '{ic: 4'h3, fn: 4'h0, ra: 4'h1, rb: 4'h2, vc: 64'h1122334455667788};
        drive(1'b0, 1'b1, 64'd1020, f, acc);
        send(f);
        idle(2);
        chk("range_err_code", 64'(err_code_o), 64'd2);
        do_reset();
        drive(1'b0, 1'b1, 64'd1014, f, acc);
        send(f);
        idle(12);
        chk("edge_next_addr", next_addr_o, 64'd1024);
        chk("edge_no_err", 64'(err_o), 64'd0);

        // Reset in the middle of CALL
        do_reset();
        send('{ic: 4'h8, fn: 4'h0, ra: 4'h0, rb: 4'h0, vc: 64'hDEADBEEFCAFE0123});
        idle(3);
        do_reset();
        chk("midrst_mem_we", 64'(mem_we_o), 64'd0);
        chk("midrst_next_addr", next_addr_o, 64'd0);
        chk("midrst_ready", 64'(in_ready_o), 64'd1);
        idle(2);

        // addr_load beats in_valid in IDLE
        f = '{ic: 4'h6, fn: 4'h1, ra: 4'h5, rb: 4'h6, vc: 64'h0};
        drive(1'b1, 1'b1, 64'd100, f, acc);
        send(f);
        idle(4);
        chk("load_next_addr", next_addr_o, 64'd102);

        // Randomized traffic
        do_reset();
        for (int it = 0; it < 600; it++) begin
            if (m_err) begin
                idle(2);
                do_reset();
                continue;
            end
            f.ic = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(12, 15))
                                                : 4'($urandom_range(0, 11));
            f.fn = 4'($urandom);
            f.ra = 4'($urandom);
            f.rb = 4'($urandom);
            f.vc = {$urandom, $urandom};
            v  = ($urandom_range(0, 9) < 7);
            ld = ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 1023))
                                             : 64'($urandom_range(1000, 1023));
            drive(v, ld, a, f, acc);
        end

        // Drain
        for (int i = 0; i < 100 && q.size() > 0; i++) idle(1);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
